// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM states, key-code table
// and small index helpers.
package keypad_pkg;

   typedef enum logic [1:0] {
      ST_SCAN       = 2'd0,
      ST_DB_PRESS   = 2'd1,
      ST_HELD       = 2'd2,
      ST_DB_RELEASE = 2'd3
   } kp_state_e;

   localparam int unsigned SCAN_DIV_DEF        = 1000;
   localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;

   // ASCII codes indexed by {row[1:0], col[1:0]}; entry 0 is the rightmost byte.
   localparam logic [15:0][7:0] KEY_TABLE = {
      8'h44, 8'h23, 8'h30, 8'h2A,   // row3: D # 0 *
      8'h43, 8'h39, 8'h38, 8'h37,   // row2: C 9 8 7
      8'h42, 8'h36, 8'h35, 8'h34,   // row1: B 6 5 4
      8'h41, 8'h33, 8'h32, 8'h31    // row0: A 3 2 1
   };

   // Lowest set column wins when several lines are active.
   function automatic logic [1:0] col_index(input logic [3:0] c);
      logic [1:0] idx;
      if (c[0])      idx = 2'd0;
      else if (c[1]) idx = 2'd1;
      else if (c[2]) idx = 2'd2;
      else           idx = 2'd3;
      return idx;
   endfunction

   function automatic logic [1:0] row_index(input logic [3:0] r);
      logic [1:0] idx;
      if (r[0])      idx = 2'd0;
      else if (r[1]) idx = 2'd1;
      else if (r[2]) idx = 2'd2;
      else           idx = 2'd3;
      return idx;
   endfunction

   function automatic logic [7:0] key_code(input logic [3:0] row_oh, input logic [3:0] col_vec);
      return KEY_TABLE[{row_index(row_oh), col_index(col_vec)}];
   endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Debounce counter: counts consecutive stable cycles in the press or release
// phase and strobes accept/release on the last required cycle.
module keypad_debounce
   import keypad_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear_i,
   input  logic       press_phase_i,
   input  logic       release_phase_i,
   input  logic [3:0] col_i,
   input  logic [3:0] ref_i,
   output logic       accept_o,
   output logic       release_o
);

   localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          stable;
   logic          done;

   // Stability condition and terminal-count strobes for the active phase.
   always_comb begin
      stable    = 1'b0;
      if (press_phase_i)   stable = (col_i == ref_i);
      if (release_phase_i) stable = (col_i == 4'b0000);
      done      = (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
      accept_o  = press_phase_i & stable & done;
      release_o = release_phase_i & stable & done;
   end

   // Counter next value: cleared on phase entry, advanced while stable.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i)
         cnt_d = '0;
      else if ((press_phase_i || release_phase_i) && stable && !done)
         cnt_d = cnt_q + 1'b1;
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

endmodule

// File: rtl/keypad_top.sv
// 4x4 matrix keypad scanner: row rotation, column synchroniser, press/release
// FSM and ASCII encoder with registered outputs.
module keypad_top
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV        = SCAN_DIV_DEF,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] in,
   output logic [3:0] row_select,
   output logic [7:0] enc_out,
   output logic       pressed
);

   localparam int unsigned SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [3:0]     sync1_q, sync2_q;
   logic [3:0]     col;
   kp_state_e      state_q, state_d;
   logic [3:0]     row_q, row_d;
   logic [SCW-1:0] scan_cnt_q, scan_cnt_d;
   logic [3:0]     ref_q, ref_d;
   logic [7:0]     enc_q, enc_d;
   logic           pressed_q, pressed_d;
   logic           db_clear;
   logic           db_accept;
   logic           db_release;

   assign col        = sync2_q;
   assign row_select = row_q;
   assign enc_out    = enc_q;
   assign pressed    = pressed_q;

   // Two-flop synchroniser for the asynchronous column lines.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= in;
         sync2_q <= sync1_q;
      end
   end

   keypad_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk             (clk),
      .rst             (rst),
      .clear_i         (db_clear),
      .press_phase_i   (state_q == ST_DB_PRESS),
      .release_phase_i (state_q == ST_DB_RELEASE),
      .col_i           (col),
      .ref_i           (ref_q),
      .accept_o        (db_accept),
      .release_o       (db_release)
   );

   // FSM next-state, row rotation, capture and encoder logic.
   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      scan_cnt_d = scan_cnt_q;
      ref_d      = ref_q;
      enc_d      = enc_q;
      pressed_d  = pressed_q;
      db_clear   = 1'b0;
      case (state_q)
         ST_SCAN: begin
            if (col == 4'b0000) begin
               if (scan_cnt_q == SCW'(SCAN_DIV - 1)) begin
                  scan_cnt_d = '0;
                  row_d      = {row_q[2:0], row_q[3]};
               end else begin
                  scan_cnt_d = scan_cnt_q + 1'b1;
               end
            end else begin
               ref_d      = col;
               db_clear   = 1'b1;
               scan_cnt_d = '0;
               state_d    = ST_DB_PRESS;
            end
         end
         ST_DB_PRESS: begin
            if (db_accept) begin
               enc_d     = key_code(row_q, ref_q);
               pressed_d = 1'b1;
               state_d   = ST_HELD;
            end else if (col != ref_q) begin
               state_d = ST_SCAN;
            end
         end
         ST_HELD: begin
            pressed_d = 1'b1;
            if (col == 4'b0000) begin
               db_clear = 1'b1;
               state_d  = ST_DB_RELEASE;
            end
         end
         ST_DB_RELEASE: begin
            if (db_release) begin
               pressed_d = 1'b0;
               state_d   = ST_SCAN;
            end else if (col != 4'b0000) begin
               state_d = ST_HELD;
            end
         end
         default: state_d = ST_SCAN;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_SCAN;
         row_q      <= 4'b0001;
         scan_cnt_q <= '0;
         ref_q      <= '0;
         enc_q      <= 8'h00;
         pressed_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         scan_cnt_q <= scan_cnt_d;
         ref_q      <= ref_d;
         enc_q      <= enc_d;
         pressed_q  <= pressed_d;
      end
   end

endmodule

// File: tb/tb_keypad_top.sv
// Self-checking bench for keypad_top with a scoreboard of expected key codes.
module tb_keypad_top;

   logic       clk;
   logic       rst;
   logic [3:0] in;
   logic [3:0] row_select;
   logic [7:0] enc_out;
   logic       pressed;

   int unsigned total;
   int unsigned bad;
   int unsigned edges;
   logic        prev_p;
   logic [7:0]  exp_q [$];

   keypad_top #(
      .SCAN_DIV        (4),
      .DEBOUNCE_CYCLES (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in         (in),
      .row_select (row_select),
      .enc_out    (enc_out),
      .pressed    (pressed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Scoreboard: every rising edge of pressed pops one expected code.
   always @(negedge clk) begin
      if (rst && pressed && !prev_p) begin
         edges++;
         if (exp_q.size() == 0) chk("spurious_press", 1, 0);
         else chk("enc_on_press", {24'h0, enc_out}, {24'h0, exp_q.pop_front()});
      end
      prev_p = pressed;
   end

   task automatic wait_row(input logic [3:0] target);
      int unsigned n;
      n = 0;
      while (row_select == target && n < 40) begin @(negedge clk); n++; end
      while (row_select != target && n < 80) begin @(negedge clk); n++; end
      if (row_select != target) chk("row_wait_timeout", 0, 1);
   endtask

   task automatic wait_pressed(input logic val, input string tag);
      int unsigned n;
      n = 0;
      while (pressed != val && n < 60) begin @(negedge clk); n++; end
      if (pressed != val) chk(tag, 0, 1);
   endtask

   task automatic press_key(input logic [3:0] row, input logic [3:0] colv,
                            input logic [7:0] code, input int unsigned hold);
      exp_q.push_back(code);
      wait_row(row);
      in = colv;
      wait_pressed(1'b1, "press_timeout");
      chk("row_frozen", {28'h0, row_select}, {28'h0, row});
      repeat (hold) @(negedge clk);
      chk("held_pressed", {31'h0, pressed}, 1);
      in = 4'b0000;
      wait_pressed(1'b0, "release_timeout");
      chk("row_resume", {28'h0, row_select}, {28'h0, row});
   endtask

   initial begin
      logic [7:0]  enc_save;
      int unsigned e0;
      total  = 0;
      bad    = 0;
      edges  = 0;
      prev_p = 1'b0;
      in     = 4'b0000;
      rst    = 1'b0;
      #23;
      chk("reset_row", {28'h0, row_select}, 32'h1);
      chk("reset_enc", {24'h0, enc_out}, 0);
      chk("reset_pressed", {31'h0, pressed}, 0);
      @(negedge clk);
      rst = 1'b1;

      // Single press: row0 col2 -> "3".
      press_key(4'b0001, 4'b0100, 8'h33, 20);
      chk("enc_hold_after_release", {24'h0, enc_out}, 32'h33);

      // Repeated key on row1 col2 -> "6" three times.
      e0 = edges;
      for (int i = 0; i < 3; i++) press_key(4'b0010, 4'b0100, 8'h36, 5);
      chk("repeat_edges", edges - e0, 3);

      // Bounce never stable long enough to accept.
      enc_save = enc_out;
      e0 = edges;
      for (int i = 0; i < 5; i++) begin
         in = 4'b0100; repeat (3) @(negedge clk);
         in = 4'b0000; repeat (3) @(negedge clk);
      end
      repeat (20) @(negedge clk);
      chk("bounce_pressed", {31'h0, pressed}, 0);
      chk("bounce_enc", {24'h0, enc_out}, {24'h0, enc_save});
      chk("bounce_edges", edges - e0, 0);

      // Different keys, including multi-column lowest-index priority.
      press_key(4'b0100, 4'b1000, 8'h43, 4);
      press_key(4'b1000, 4'b0001, 8'h2A, 4);
      press_key(4'b1000, 4'b1010, 8'h30, 4);

      // Second key while held on "5" is ignored.
      e0 = edges;
      exp_q.push_back(8'h35);
      wait_row(4'b0010);
      in = 4'b0010;
      wait_pressed(1'b1, "hold_press_timeout");
      repeat (5) @(negedge clk);
      in = 4'b1010;
      repeat (30) @(negedge clk);
      chk("second_key_enc", {24'h0, enc_out}, 32'h35);
      chk("second_key_pressed", {31'h0, pressed}, 1);
      chk("second_key_edges", edges - e0, 1);
      in = 4'b0000;
      wait_pressed(1'b0, "hold_release_timeout");

      // Reset in the middle of a held press.
      exp_q.push_back(8'h31);
      wait_row(4'b0001);
      in = 4'b0001;
      wait_pressed(1'b1, "pre_reset_press_timeout");
      repeat (3) @(negedge clk);
      rst = 1'b0;
      in  = 4'b0000;
      #1;
      chk("midreset_row", {28'h0, row_select}, 32'h1);
      chk("midreset_enc", {24'h0, enc_out}, 0);
      chk("midreset_pressed", {31'h0, pressed}, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         chk("post_reset_scan", {28'h0, row_select}, 32'h1 << ((k / 4) % 4));
      end

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got=running expected=finished");
      $fatal(1);
   end

endmodule
